shift_serializer: RTL and testbench

Parallel-to-serial converter built on a registered static left shift. Accepts one WIDTH-bit word through a valid/ready handshake. Emits it MSB-first as CHUNK-bit slices through a second valid/ready handshake, shifting the word left by CHUNK bits and back-filling with PAD_VALUE on each accepted slice. Sits directly downstream of the static left shifter in serial transmit paths: word producers feed it, and serial links or CRC/scramblers consume its output.

---
 rtl/shift_serializer.sv | 68 ++++++
 tb/tb_shift_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter: loads a WIDTH-bit word, emits CHUNK-bit slices MSB-first.
// Define SHIFT_SERIALIZER_BACK_TO_BACK_EN for zero-bubble word-to-word streaming.
module shift_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   CHUNK     = 1,
  parameter logic PAD_VALUE = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] parallel_data,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  output logic [CHUNK-1:0] serial_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int SLICES = WIDTH / CHUNK;
  localparam int CW     = $clog2(SLICES + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             valid_q;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] shifted;

  generate
    if (CHUNK == WIDTH) begin : g_full
      assign shifted = {WIDTH{PAD_VALUE}};
    end else begin : g_part
      assign shifted = {shreg[WIDTH-CHUNK-1:0], {CHUNK{PAD_VALUE}}};
    end
  endgenerate

`ifdef SHIFT_SERIALIZER_BACK_TO_BACK_EN
  // Final slice leaving this edge frees the register for the next word.
  assign parallel_ready = (count == '0) ||
                          (count == CW'(1) && serial_ready);
`else
  assign parallel_ready = (count == '0);
`endif

  assign load  = parallel_valid && parallel_ready;
  assign shift = valid_q && serial_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg   <= {WIDTH{PAD_VALUE}};
      count   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shreg   <= parallel_data;
      count   <= CW'(SLICES);
      valid_q <= 1'b1;
    end else if (shift) begin
      shreg   <= shifted;
      count   <= count - CW'(1);
      valid_q <= (count != CW'(1));
    end
  end

  assign serial_data  = shreg[WIDTH-1 -: CHUNK];
  assign serial_valid = valid_q;
  assign busy         = valid_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: CHUNK=1/PAD=0 and CHUNK=2/PAD=1 instances
// checked every cycle against a word/slice-index model.
module tb_shift_serializer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pv[2] = '{1'b0, 1'b0};
  logic [7:0] pd[2] = '{8'h00, 8'h00};
  logic       sr[2] = '{1'b0, 1'b0};
  logic       pr[2];
  logic       sv[2];
  logic       bz[2];
  logic [0:0] sd0;
  logic [1:0] sd1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

`ifdef SHIFT_SERIALIZER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  shift_serializer #(.WIDTH(8), .CHUNK(1), .PAD_VALUE(1'b0)) u_dut (
    .clock(clock), .resetn(resetn),
    .parallel_data(pd[0]), .parallel_valid(pv[0]),
    .parallel_ready(pr[0]), .serial_data(sd0),
    .serial_valid(sv[0]), .serial_ready(sr[0]), .busy(bz[0])
  );

  shift_serializer #(.WIDTH(8), .CHUNK(2), .PAD_VALUE(1'b1)) u_dut2 (
    .clock(clock), .resetn(resetn),
    .parallel_data(pd[1]), .parallel_valid(pv[1]),
    .parallel_ready(pr[1]), .serial_data(sd1),
    .serial_valid(sv[1]), .serial_ready(sr[1]), .busy(bz[1])
  );

  always #5 clock = ~clock;

  function automatic int chunk_of(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit pad_of(int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [7:0] act_sd(int d);
    return (d == 0) ? {7'b0, sd0} : {6'b0, sd1};
  endfunction

  // Model: last accepted word, slices already sent, slices remaining.
  logic [7:0] m_word[2] = '{8'h00, 8'hFF};
  int         m_k[2]    = '{0, 0};
  int         m_left[2] = '{0, 0};

  function automatic bit exp_ready(int d);
    return (m_left[d] == 0) || (B2B && m_left[d] == 1 && sr[d]);
  endfunction

  function automatic logic [7:0] exp_slice(int d);
    logic [15:0] x;
    int c;
    c = chunk_of(d);
    x = {m_word[d], {8{pad_of(d)}}};
    x = x << (m_k[d] * c);
    return 8'(x[15:8] >> (8 - c));
  endfunction

  always @(posedge clock or negedge resetn) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        m_word[d] = pad_of(d) ? 8'hFF : 8'h00;
        m_k[d]    = 0;
        m_left[d] = 0;
      end else if (pv[d] && exp_ready(d)) begin
        m_word[d] = pd[d];
        m_k[d]    = 0;
        m_left[d] = 8 / chunk_of(d);
      end else if (m_left[d] > 0 && sr[d]) begin
        m_k[d]    = m_k[d] + 1;
        m_left[d] = m_left[d] - 1;
      end
    end
  end

  task automatic chk(input string nm, input int d,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h want %h", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, {7'b0, sv[d]}, {7'b0, m_left[d] > 0});
      chk("busy", d, {7'b0, bz[d]}, {7'b0, m_left[d] > 0});
      chk("data", d, act_sd(d), exp_slice(d));
      chk("ready", d, {7'b0, pr[d]}, {7'b0, exp_ready(d)});
    end
  end

  // Observed transfers, with the cycle they happened in.
  logic [7:0] log0[$];
  int         lcyc0[$];
  logic [7:0] log1[$];

  always @(posedge clock) begin
    cyc++;
    if (resetn && sv[0] && sr[0]) begin
      log0.push_back(act_sd(0));
      lcyc0.push_back(cyc);
    end
    if (resetn && sv[1] && sr[1]) log1.push_back(act_sd(1));
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    pd[d] = w;
    pv[d] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1 ok = pr[d];
      tick();
    end
    pv[d] = 1'b0;
    chk("send_accept", d, {7'b0, ok}, 8'h01);
  endtask

  task automatic wait_log(input int d, input int n);
    int sz;
    sz = (d == 0) ? log0.size() : log1.size();
    for (int i = 0; i < 60 && sz < n; i++) begin
      tick();
      sz = (d == 0) ? log0.size() : log1.size();
    end
    chk("xfer_count", d, 8'(sz), 8'(n));
  endtask

  task automatic chk_bits(input string nm, input logic [7:0] w, input int off);
    for (int i = 0; i < 8; i++) begin
      chk(nm, 0, (log0.size() > off + i) ? log0[off + i] : 8'hxx,
          {7'b0, w[7 - i]});
    end
  endtask

  initial begin
    logic [7:0] exp2[4];
    int span;
    exp2 = '{8'h03, 8'h00, 8'h01, 8'h02};

    tick();
    tick();
    chk("rst_valid", 0, {7'b0, sv[0]}, 8'h00);
    chk("rst_busy", 0, {7'b0, bz[0]}, 8'h00);
    chk("rst_data", 0, act_sd(0), 8'h00);
    chk("rst_ready", 0, {7'b0, pr[0]}, 8'h01);
    chk("rst_data", 1, act_sd(1), 8'h03);
    chk("rst_ready", 1, {7'b0, pr[1]}, 8'h01);
    resetn = 1'b1;
    tick();

    // Basic serialization
    sr[0] = 1'b1;
    log0.delete();
    send(0, 8'hB2);
    wait_log(0, 8);
    tick();
    chk_bits("basic_seq", 8'hB2, 0);
    chk("basic_busy", 0, {7'b0, bz[0]}, 8'h00);
    chk("basic_shreg", 0, u_dut.shreg, 8'h00);

    // Backpressure 1,0,0,...
    sr[0] = 1'b0;
    log0.delete();
    send(0, 8'hB2);
    for (int i = 0; i < 40 && log0.size() < 8; i++) begin
      sr[0] = (i % 3 == 0);
      tick();
    end
    sr[0] = 1'b1;
    tick();
    tick();
    chk("bp_count", 0, 8'(log0.size()), 8'd8);
    chk_bits("bp_seq", 8'hB2, 0);

    // Multi-bit slices, pad 1
    sr[1] = 1'b1;
    log1.delete();
    send(1, 8'hC6);
    wait_log(1, 4);
    tick();
    for (int i = 0; i < 4; i++)
      chk("c2_seq", 1, (log1.size() > i) ? log1[i] : 8'hxx, exp2[i]);
    chk("c2_idle", 1, act_sd(1), 8'h03);
    sr[1] = 1'b0;

    // Back-to-back words
    log0.delete();
    lcyc0.delete();
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_log(0, 16);
    span = (lcyc0.size() == 16) ? lcyc0[15] - lcyc0[0] + 1 : 0;
    chk("b2b_span", 0, 8'(span), B2B ? 8'd16 : 8'd17);
    chk_bits("b2b_w0", 8'hA5, 0);
    chk_bits("b2b_w1", 8'h3C, 8);
    tick();

    // Reset mid-word
    log0.delete();
    send(0, 8'hFF);
    wait_log(0, 3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 0, {7'b0, sv[0]}, 8'h00);
    chk("mid_rst_busy", 0, {7'b0, bz[0]}, 8'h00);
    chk("mid_rst_data", 0, act_sd(0), 8'h00);
    chk("mid_rst_ready", 0, {7'b0, pr[0]}, 8'h01);
    tick();
    resetn = 1'b1;
    log0.delete();
    tick();
    tick();
    chk("post_rst_xfers", 0, 8'(log0.size()), 8'd0);
    send(0, 8'h5A);
    wait_log(0, 8);
    chk_bits("post_rst_seq", 8'h5A, 0);
    tick();

    // Ignored parallel_valid while active
    log0.delete();
    send(0, 8'h96);
    tick();
    tick();
    pd[0] = 8'h00;
    pv[0] = 1'b1;
    #1;
    chk("ign_ready", 0, {7'b0, pr[0]}, 8'h00);
    tick();
    pv[0] = 1'b0;
    wait_log(0, 8);
    tick();
    chk("ign_count", 0, 8'(log0.size()), 8'd8);
    chk_bits("ign_seq", 8'h96, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
